// File: rtl/frame_buf_pkg.sv
// Shared constants and helpers for the multi-channel frame buffer controller.
// Polarity names, drop-counter sizing and channel region base computation.
package frame_buf_pkg;

    localparam logic ASSERT_L   = 1'b0;
    localparam logic DEASSERT_L = 1'b1;
    localparam logic ASSERT_H   = 1'b1;
    localparam logic DEASSERT_H = 1'b0;

    localparam int               DROP_W   = 16;
    localparam logic [DROP_W-1:0] DROP_MAX = 16'hFFFF;

    function automatic logic [63:0] region_base(input logic [63:0] base,
                                                input logic [63:0] ch,
                                                input logic [63:0] size);
        return base + ch * size;
    endfunction

endpackage

// File: rtl/frame_buf_rr_arb.sv
// Round-robin arbiter: one-hot grant starting after the last accepted index.
// After reset the first search starts at index 0.
module frame_buf_rr_arb #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] gnt
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] idx;
    logic [IW-1:0] pick;
    logic          found;

    always_comb begin
        gnt   = '0;
        pick  = last_q;
        idx   = last_q;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(last_q) + k) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        if (found) gnt[pick] = 1'b1;
        last_d = (accept && found) ? pick : last_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) last_q <= IW'(N - 1);
        else        last_q <= last_d;
    end

endmodule

// File: rtl/frame_buf_mc.sv
// Multi-channel frame buffer command scheduler for a shared Avalon port.
// Optional write-drop statistics enabled by defining FRAME_BUF_STATS_EN.
module frame_buf_mc
    import frame_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 29,
    parameter int BASE_ADDR  = 2,
    parameter int BUF_SIZE   = 307200,
    parameter int NUM_CH     = 2
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_CH-1:0]                           wr_en,
    input  logic [NUM_CH-1:0]                           rd_en,
    input  logic                                        ram_rdy,
    input  logic                                        avl_ready,
    output logic                                        avl_write_req,
    output logic                                        avl_read_req,
    output logic [ADDR_WIDTH-1:0]                       avl_addr,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] avl_ch,
    output logic [NUM_CH-1:0]                           full,
    output logic [NUM_CH-1:0]                           empty,
    output logic [NUM_CH-1:0]                           frame_wr_done,
    output logic [NUM_CH-1:0]                           frame_rd_done,
    output logic [NUM_CH*16-1:0]                        drop_cnt
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;

    if ((64'(BASE_ADDR) + 64'(NUM_CH) * 64'(BUF_SIZE) > (64'd1 << ADDR_WIDTH)) || (DATA_WIDTH < 1))
    begin : g_param_chk
        $error("frame_buf_mc: channel regions do not fit in ADDR_WIDTH");
    end

    logic [PW-1:0]         wr_ptr_q [NUM_CH];
    logic [PW-1:0]         wr_ptr_d [NUM_CH];
    logic [PW-1:0]         rd_ptr_q [NUM_CH];
    logic [PW-1:0]         rd_ptr_d [NUM_CH];
    logic [NUM_CH-1:0]     wr_c_q, wr_c_d, rd_c_q, rd_c_d;
    logic                  wr_req_q, wr_req_d, rd_req_q, rd_req_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         ch_q, ch_d;
    logic [NUM_CH-1:0]     wr_done_q, wr_done_d, rd_done_q, rd_done_d;
    logic [NUM_CH-1:0]     wr_elig, rd_elig, wr_gnt, rd_gnt;
    logic                  go, wr_accept, rd_accept;

    function automatic logic [ADDR_WIDTH-1:0] chan_addr(input int c, input logic [PW-1:0] p);
        return ADDR_WIDTH'(region_base(64'(BASE_ADDR), 64'(c), 64'(BUF_SIZE)) + 64'(p));
    endfunction

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            empty[c]   = (wr_ptr_q[c] == rd_ptr_q[c]) && (wr_c_q[c] == rd_c_q[c]);
            full[c]    = (wr_ptr_q[c] == rd_ptr_q[c]) && (wr_c_q[c] != rd_c_q[c]);
            wr_elig[c] = (wr_en[c] == ASSERT_L) && !full[c];
            rd_elig[c] = (rd_en[c] == ASSERT_L) && !empty[c];
        end
    end

    // Writes always win; reads only go when no channel has an eligible write.
    assign go        = ram_rdy && avl_ready;
    assign wr_accept = go && (|wr_elig);
    assign rd_accept = go && !(|wr_elig) && (|rd_elig);

    frame_buf_rr_arb #(.N(NUM_CH)) u_wr_arb (
        .clk(clk), .reset(reset), .req(wr_elig), .accept(wr_accept), .gnt(wr_gnt)
    );

    frame_buf_rr_arb #(.N(NUM_CH)) u_rd_arb (
        .clk(clk), .reset(reset), .req(rd_elig), .accept(rd_accept), .gnt(rd_gnt)
    );

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        wr_c_d    = wr_c_q;
        rd_c_d    = rd_c_q;
        wr_req_d  = DEASSERT_H;
        rd_req_d  = DEASSERT_H;
        addr_d    = addr_q;
        ch_d      = ch_q;
        wr_done_d = '0;
        rd_done_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_accept && wr_gnt[c]) begin
                wr_req_d = ASSERT_H;
                addr_d   = chan_addr(c, wr_ptr_q[c]);
                ch_d     = CW'(c);
                if (wr_ptr_q[c] == PW'(BUF_SIZE - 1)) begin
                    wr_ptr_d[c]  = '0;
                    wr_c_d[c]    = ~wr_c_q[c];
                    wr_done_d[c] = ASSERT_H;
                end else begin
                    wr_ptr_d[c] = wr_ptr_q[c] + PW'(1);
                end
            end
            if (rd_accept && rd_gnt[c]) begin
                rd_req_d = ASSERT_H;
                addr_d   = chan_addr(c, rd_ptr_q[c]);
                ch_d     = CW'(c);
                if (rd_ptr_q[c] == PW'(BUF_SIZE - 1)) begin
                    rd_ptr_d[c]  = '0;
                    rd_c_d[c]    = ~rd_c_q[c];
                    rd_done_d[c] = ASSERT_H;
                end else begin
                    rd_ptr_d[c] = rd_ptr_q[c] + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
            end
            wr_c_q    <= '0;
            rd_c_q    <= '0;
            wr_req_q  <= DEASSERT_H;
            rd_req_q  <= DEASSERT_H;
            addr_q    <= '0;
            ch_q      <= '0;
            wr_done_q <= '0;
            rd_done_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_c_q    <= wr_c_d;
            rd_c_q    <= rd_c_d;
            wr_req_q  <= wr_req_d;
            rd_req_q  <= rd_req_d;
            addr_q    <= addr_d;
            ch_q      <= ch_d;
            wr_done_q <= wr_done_d;
            rd_done_q <= rd_done_d;
        end
    end

    assign avl_write_req = wr_req_q;
    assign avl_read_req  = rd_req_q;
    assign avl_addr      = addr_q;
    assign avl_ch        = ch_q;
    assign frame_wr_done = wr_done_q;
    assign frame_rd_done = rd_done_q;

`ifdef FRAME_BUF_STATS_EN
    logic [DROP_W-1:0] drop_q [NUM_CH];
    logic [DROP_W-1:0] drop_d [NUM_CH];

    always_comb begin
        drop_d = drop_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ram_rdy && (wr_en[c] == ASSERT_L) && full[c] && (drop_q[c] != DROP_MAX))
                drop_d[c] = drop_q[c] + DROP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) drop_q[c] <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    always_comb begin
        drop_cnt = '0;
        for (int c = 0; c < NUM_CH; c++) drop_cnt[c*DROP_W +: DROP_W] = drop_q[c];
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_buf_mc.sv
// Bench for frame_buf_mc: directed scenarios plus random traffic against an
// occupancy-based reference model of the two channel buffers.
module tb_frame_buf_mc;
    localparam int NC = 2;
    localparam int BS = 4;
    localparam int BA = 2;
    localparam int AW = 29;
`ifdef FRAME_BUF_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [NC-1:0] wr_en, rd_en;
    logic          ram_rdy, avl_ready;
    logic          avl_write_req, avl_read_req;
    logic [AW-1:0] avl_addr;
    logic [0:0]    avl_ch;
    logic [NC-1:0] full, empty, frame_wr_done, frame_rd_done;
    logic [NC*16-1:0] drop_cnt;

    frame_buf_mc #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .BASE_ADDR(BA),
                   .BUF_SIZE(BS), .NUM_CH(NC)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en),
        .ram_rdy(ram_rdy), .avl_ready(avl_ready),
        .avl_write_req(avl_write_req), .avl_read_req(avl_read_req),
        .avl_addr(avl_addr), .avl_ch(avl_ch), .full(full), .empty(empty),
        .frame_wr_done(frame_wr_done), .frame_rd_done(frame_rd_done),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: words held per channel, next write/read word index,
    // and the last channel served in each class.
    int occ [NC];
    int wi  [NC];
    int ri  [NC];
    int drops [NC];
    int last_w, last_r;
    int exp_wr, exp_rd, exp_addr, exp_ch;
    logic [NC-1:0] exp_wdone, exp_rdone;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int g;
        int c;
        exp_wr = 0;
        exp_rd = 0;
        exp_wdone = '0;
        exp_rdone = '0;
        if (!reset) begin
            for (int i = 0; i < NC; i++) begin
                occ[i] = 0; wi[i] = 0; ri[i] = 0; drops[i] = 0;
            end
            last_w = NC - 1;
            last_r = NC - 1;
            exp_addr = 0;
            exp_ch = 0;
            return;
        end
        if (ram_rdy && STATS != 0) begin
            for (int i = 0; i < NC; i++)
                if (!wr_en[i] && occ[i] == BS && drops[i] < 65535) drops[i]++;
        end
        if (ram_rdy && avl_ready) begin
            g = -1;
            for (int k = 1; k <= NC; k++) begin
                c = (last_w + k) % NC;
                if (g < 0 && !wr_en[c] && occ[c] < BS) g = c;
            end
            if (g >= 0) begin
                exp_wr = 1;
                exp_addr = BA + g * BS + wi[g];
                exp_ch = g;
                if (wi[g] == BS - 1) exp_wdone[g] = 1'b1;
                wi[g] = (wi[g] + 1) % BS;
                occ[g]++;
                last_w = g;
            end else begin
                for (int k = 1; k <= NC; k++) begin
                    c = (last_r + k) % NC;
                    if (g < 0 && !rd_en[c] && occ[c] > 0) g = c;
                end
                if (g >= 0) begin
                    exp_rd = 1;
                    exp_addr = BA + g * BS + ri[g];
                    exp_ch = g;
                    if (ri[g] == BS - 1) exp_rdone[g] = 1'b1;
                    ri[g] = (ri[g] + 1) % BS;
                    occ[g]--;
                    last_r = g;
                end
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        chk("wr_req", avl_write_req, exp_wr);
        chk("rd_req", avl_read_req, exp_rd);
        if (exp_wr != 0 || exp_rd != 0) begin
            chk("addr", avl_addr, exp_addr);
            chk("ch", avl_ch, exp_ch);
        end
        chk("wr_done", frame_wr_done, exp_wdone);
        chk("rd_done", frame_rd_done, exp_rdone);
        for (int i = 0; i < NC; i++) begin
            chk("full", full[i], occ[i] == BS);
            chk("empty", empty[i], occ[i] == 0);
            chk("drop", drop_cnt[i*16 +: 16], drops[i]);
        end
        chk("excl", avl_write_req & avl_read_req, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
    endtask

    int s38 [6] = '{2, 6, 3, 7, 4, 8};

    initial begin
        reset = 1'b0; wr_en = 2'b11; rd_en = 2'b11; ram_rdy = 1'b1; avl_ready = 1'b1;
        cycle();
        cycle();
        reset = 1'b1;
        chk("rst_empty", empty, 2'b11);
        chk("rst_full", full, 2'b00);
        chk("rst_strobe", {avl_write_req, avl_read_req}, 2'b00);

        // ch0 fills one frame
        wr_en = 2'b10;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("s37_addr", avl_addr, BA + i);
            chk("s37_done", frame_wr_done[0], i == 3);
        end
        wr_en = 2'b11;
        chk("s37_full", full[0], 1'b1);

        // write and read on the full channel: read first, write next
        wr_en = 2'b10; rd_en = 2'b10;
        cycle();
        chk("s39_rd", avl_read_req, 1'b1);
        chk("s39_rd_addr", avl_addr, 2);
        cycle();
        chk("s39_wr", avl_write_req, 1'b1);
        chk("s39_wr_addr", avl_addr, 2);
        wr_en = 2'b11; rd_en = 2'b11;
        cycle();

        // both channels writing alternate
        do_reset();
        wr_en = 2'b00;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("s38_addr", avl_addr, s38[i]);
        end
        wr_en = 2'b11;

        // avl_ready stall mid-frame
        do_reset();
        wr_en = 2'b10;
        cycle();
        cycle();
        avl_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("s40_stall", {avl_write_req, avl_read_req}, 2'b00);
        end
        chk("s40_empty", empty, 2'b10);
        avl_ready = 1'b1;
        cycle();
        chk("s40_resume", avl_addr, 4);
        // ram_rdy low freezes everything
        ram_rdy = 1'b0;
        cycle();
        cycle();
        ram_rdy = 1'b1;
        cycle();
        chk("rdy_resume", avl_addr, 5);
        wr_en = 2'b11;

        // drops on full ch1
        do_reset();
        wr_en = 2'b01;
        for (int i = 0; i < 9; i++) cycle();
        chk("s41_drop", drop_cnt[31:16], (STATS != 0) ? 5 : 0);
        wr_en = 2'b11;

        // reset mid-frame discards data
        do_reset();
        wr_en = 2'b10;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        chk("s42_empty", empty, 2'b11);
        cycle();
        chk("s42_addr", avl_addr, 2);
        wr_en = 2'b11;

        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 99) != 0);
            wr_en     = 2'($urandom);
            rd_en     = 2'($urandom);
            ram_rdy   = ($urandom_range(0, 9) != 0);
            avl_ready = ($urandom_range(0, 4) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_buf_mc.md
FRAME_BUF_MC -- requirements
Module: frame_buf_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory word width (carried for the top level, no datapath here).
REQ-002 SHALL have parameter ADDR_WIDTH, default 29, Avalon word-address width.
REQ-003 SHALL have parameter BASE_ADDR, default 2, first word of channel 0's region.
REQ-004 SHALL have parameter BUF_SIZE, default 307200, words per frame (640x480).
REQ-005 SHALL have parameter NUM_CH, default 2, independent frame channels (stereo pair).
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 wr_en  in  NUM_CH  per-channel write request, active-low.
REQ-009 rd_en  in  NUM_CH  per-channel read request, active-low.
REQ-010 ram_rdy  in  1  memory calibration done; all state frozen while low.
REQ-011 avl_ready  in  1  Avalon port can accept a command this cycle.
REQ-012 avl_write_req / avl_read_req  out  1 each  registered single-cycle command strobes.
REQ-013 avl_addr  out  ADDR_WIDTH  registered command address.
REQ-014 avl_ch  out  $clog2(NUM_CH) (min 1)  channel owning the current command.
REQ-015 full / empty  out  NUM_CH each  per-channel buffer status, combinational from pointers.
REQ-016 frame_wr_done / frame_rd_done  out  NUM_CH each  one-cycle pulse on last word of a frame.
REQ-017 drop_cnt  out  NUM_CH*16  per-channel 16-bit write-drop counters.

Function
REQ-018 Each channel SHALL keep wr_ptr and rd_ptr (0..BUF_SIZE-1, width $clog2(BUF_SIZE)) plus wrap bits wr_c and rd_c.
REQ-019 empty[c] SHALL be 1 iff wr_ptr==rd_ptr and wr_c==rd_c; full[c] SHALL be 1 iff the pointers are equal and the wrap bits differ.
REQ-020 Eligible write: wr_en[c]==0 and full[c]==0. Eligible read: rd_en[c]==0 and empty[c]==0.
REQ-021 In a cycle with ram_rdy=1 and avl_ready=1, the block SHALL grant exactly one eligible request.
  - Any eligible write beats every read.
  - Within each class, round-robin over channels starting after the last channel granted in that class.
REQ-022 The grant SHALL register the matching strobe high for the next cycle.
  - avl_addr = BASE_ADDR + c*BUF_SIZE + ptr (pre-increment value); avl_ch = c.
  - Latency: request sampled at edge N, strobe valid N+1 to N+2.
REQ-023 On grant the granted pointer SHALL increment on the same edge.
  - At BUF_SIZE-1 it wraps to 0, toggles its wrap bit and pulses the matching frame_*_done[c] for one cycle.
REQ-024 If no grant, or avl_ready=0, both strobes SHALL be 0 next cycle and no pointer SHALL move.
REQ-025 A write and a read to one channel in one cycle SHALL be serialised: the write goes first, the read goes on a later cycle.
REQ-026 A write request to a full channel SHALL NOT be granted and SHALL NOT corrupt data.
REQ-027 Strobes SHALL never both be 1 in one cycle.
REQ-028 While ram_rdy=0, strobes SHALL be 0 and all pointers, wrap bits and arbiter state SHALL hold.
REQ-029 Elaboration SHALL fail if BASE_ADDR + NUM_CH*BUF_SIZE > 2**ADDR_WIDTH.

Reset
REQ-030 While reset=0 at a clock edge, the following SHALL clear, overriding everything including ram_rdy:
  - pointers, wrap bits and round-robin state (next grant starts at channel 0);
  - drop_cnt;
  - avl_write_req, avl_read_req, avl_addr, avl_ch and frame_*_done.
REQ-031 After reset every channel SHALL read empty=1 and full=0; reset mid-frame SHALL discard all buffered frames.

Configuration
REQ-032 With macro FRAME_BUF_STATS_EN defined, drop_cnt[c] SHALL increment, saturating at 16'hFFFF, each ram_rdy cycle with wr_en[c]==0 and full[c]==1.
REQ-033 Without FRAME_BUF_STATS_EN, drop_cnt SHALL still exist and be driven constant 0, with no counter logic synthesised.

Structure
REQ-034 Package frame_buf_pkg SHALL hold:
  - ASSERT_L/DEASSERT_L/ASSERT_H/DEASSERT_H constants;
  - drop-counter width and saturation constants;
  - a function computing the channel region base.
REQ-035 Round-robin selection SHALL live in sub-module frame_buf_rr_arb (NUM_CH request vector in, one-hot grant out, pointer advanced on accept), instantiated once for writes and once for reads.

Verification
REQ-036 Bench SHALL use NUM_CH=2, BUF_SIZE=4, BASE_ADDR=2 and cover:
REQ-037 Ch0 writes 4 words -> avl_addr 2,3,4,5; frame_wr_done[0] pulses with addr 5; full[0]=1.
REQ-038 Both channels hold wr_en=0 from reset -> grants alternate: addr 2(ch0), 6(ch1), 3, 7, ...
REQ-039 Ch0 full, then rd_en[0]=0 and wr_en[0]=0 together -> read addr 2 is granted; the write is granted the cycle after.
REQ-040 avl_ready=0 for 3 cycles mid-frame -> no strobes and pointers unchanged; resumes at the next address.
REQ-041 With FRAME_BUF_STATS_EN, hold wr_en[1]=0 with ch1 full for 5 cycles -> drop_cnt[1]=5; without the macro -> 0.
REQ-042 Reset asserted after 2 writes -> empty=2'b11; next write goes to addr 2.
